// File: rtl/bit_serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: op encodings, FSM states, default width.
// Optional feature macro: BSALU_SLT_EN (set-on-less-than for op=11).
package bsalu_pkg;

    localparam int BSALU_WIDTH = 8;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_serial_alu_slice.sv
// Combinational 1-bit ALU slice; the full adder always evaluates so cout is valid for every op.
module alu_slice
    import bsalu_pkg::*;
(
    input  logic       ainvert,
    input  logic       binvert,
    input  logic       cin,
    input  logic [1:0] op,
    input  logic       a,
    input  logic       b,
    output logic       result,
    output logic       cout
);

    logic x, y, sum;

    assign x    = a ^ ainvert;
    assign y    = b ^ binvert;
    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

    // op=11 passes the sum bit; the top level turns it into the SLT result.
    always_comb begin
        result = sum;
        case (op)
            OP_AND:  result = x & y;
            OP_OR:   result = x | y;
            default: result = sum;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU sequencer: one slice reused LSB-first over WIDTH cycles, start/done handshake.
// Optional feature macro: BSALU_SLT_EN (op=11 performs set-on-less-than).
module bit_serial_alu
    import bsalu_pkg::*;
#(
    parameter int WIDTH = BSALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ainvert,
    input  logic             binvert,
    input  logic             cin,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, result_q;
    logic             ainv_q, binv_q;
    logic [1:0]       op_q;
    logic             carry_q, cmsb_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, cout_q, ovf_q, zero_q;

    logic             s_res, s_cout;
    logic [WIDTH-1:0] result_d;
    logic             ovf_d, zero_d;

    alu_slice u_slice (
        .ainvert (ainv_q),
        .binvert (binv_q),
        .cin     (carry_q),
        .op      (op_q),
        .a       (a_q[cnt_q]),
        .b       (b_q[cnt_q]),
        .result  (s_res),
        .cout    (s_cout)
    );

    // Final flags from the state left after the last RUN edge; res_q[MSB] holds the MSB sum bit for SLT.
    always_comb begin
        ovf_d    = cmsb_q ^ carry_q;
        result_d = res_q;
        if (op_q == OP_SLT) begin
            result_d = '0;
`ifdef BSALU_SLT_EN
            result_d[0] = res_q[WIDTH-1] ^ ovf_d;
`endif
        end
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            result_q <= '0;
            ainv_q   <= 1'b0;
            binv_q   <= 1'b0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            cmsb_q   <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        ainv_q  <= ainvert;
                        binv_q  <= binvert;
                        op_q    <= op;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    carry_q <= s_cout;
                    res_q   <= {s_res, res_q[WIDTH-1:1]};
                    if (cnt_q == LAST) begin
                        cmsb_q  <= carry_q;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    done_q   <= 1'b1;
                    result_q <= result_d;
                    cout_q   <= carry_q;
                    ovf_q    <= ovf_d;
                    zero_q   <= zero_d;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule
